// File: rtl/alu_operand_stage.sv
// rtl/alu_operand_stage.sv - ID/EX register with MEM/WB operand forwarding ahead of the ALU.
// Optional load-use detection is built when ALU_OPSTAGE_LOADUSE_EN is defined.
module alu_operand_stage #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic [XLEN-1:0]   id_rs1_data,
    input  logic [XLEN-1:0]   id_rs2_data,
    input  logic [XLEN-1:0]   id_imm,
    input  logic [XLEN-1:0]   id_pc,
    input  logic              id_use_imm,
    input  logic              id_use_pc,
    input  logic [3:0]        id_alu_g,
    input  logic              id_reg_write,
`ifdef ALU_OPSTAGE_LOADUSE_EN
    input  logic              id_mem_read,
    output logic              load_use_hazard,
`endif
    input  logic              mem_fwd_en,
    input  logic [REG_AW-1:0] mem_fwd_rd,
    input  logic [XLEN-1:0]   mem_fwd_data,
    input  logic              wb_fwd_en,
    input  logic [REG_AW-1:0] wb_fwd_rd,
    input  logic [XLEN-1:0]   wb_fwd_data,
    output logic              id_ready,
    output logic              ex_valid,
    output logic [XLEN-1:0]   alu_a,
    output logic [XLEN-1:0]   alu_b,
    output logic [3:0]        alu_g,
    output logic [REG_AW-1:0] ex_rd,
    output logic              ex_reg_write,
    output logic [XLEN-1:0]   ex_store_data
);

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   rs1_val;
        logic [XLEN-1:0]   rs2_val;
        logic [XLEN-1:0]   imm;
        logic [XLEN-1:0]   pc;
        logic              use_imm;
        logic              use_pc;
        logic [3:0]        alu_g;
        logic              reg_write;
`ifdef ALU_OPSTAGE_LOADUSE_EN
        logic              mem_read;
`endif
    } ex_t;

    ex_t             ex_q;
    ex_t             ex_d;
    logic [XLEN-1:0] fwd_rs1;
    logic [XLEN-1:0] fwd_rs2;

    // x0 is forced to zero even if a stage claims to write it.
    function automatic logic [XLEN-1:0] fwd_sel(input logic [REG_AW-1:0] idx,
                                                input logic [XLEN-1:0]   held);
        if (idx == '0)
            return '0;
        else if (mem_fwd_en && (mem_fwd_rd == idx))
            return mem_fwd_data;
        else if (wb_fwd_en && (wb_fwd_rd == idx))
            return wb_fwd_data;
        else
            return held;
    endfunction

    always_comb begin
        fwd_rs1 = fwd_sel(ex_q.rs1, ex_q.rs1_val);
        fwd_rs2 = fwd_sel(ex_q.rs2, ex_q.rs2_val);
    end

    always_comb begin
        ex_d = ex_q;
        if (flush) begin
            ex_d = '0;
        end else if (stall) begin
            // Absorb forwards while held so the value outlives the producer's retirement.
            ex_d.rs1_val = fwd_rs1;
            ex_d.rs2_val = fwd_rs2;
        end else begin
            ex_d.valid     = id_valid;
            ex_d.rs1       = id_rs1;
            ex_d.rs2       = id_rs2;
            ex_d.rd        = id_rd;
            ex_d.rs1_val   = id_rs1_data;
            ex_d.rs2_val   = id_rs2_data;
            ex_d.imm       = id_imm;
            ex_d.pc        = id_pc;
            ex_d.use_imm   = id_use_imm;
            ex_d.use_pc    = id_use_pc;
            ex_d.alu_g     = id_alu_g;
            ex_d.reg_write = id_reg_write;
`ifdef ALU_OPSTAGE_LOADUSE_EN
            ex_d.mem_read  = id_mem_read;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            ex_q <= '0;
        else
            ex_q <= ex_d;
    end

    assign id_ready      = !stall;
    assign ex_valid      = ex_q.valid;
    assign alu_a         = ex_q.use_pc  ? ex_q.pc  : fwd_rs1;
    assign alu_b         = ex_q.use_imm ? ex_q.imm : fwd_rs2;
    assign alu_g         = ex_q.alu_g;
    assign ex_rd         = ex_q.rd;
    assign ex_reg_write  = ex_q.reg_write & ex_q.valid;
    assign ex_store_data = fwd_rs2;

`ifdef ALU_OPSTAGE_LOADUSE_EN
    assign load_use_hazard = ex_q.valid & ex_q.mem_read & (ex_q.rd != '0) & id_valid &
                             ((id_rs1 == ex_q.rd) | (id_rs2 == ex_q.rd));
`endif

endmodule

// File: tb/tb_alu_operand_stage.sv
// tb/tb_alu_operand_stage.sv - directed-vector bench for alu_operand_stage.
module tb_alu_operand_stage;

    logic        clk = 1'b0;
    logic        rst, stall, flush, id_valid;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [31:0] id_rs1_data, id_rs2_data, id_imm, id_pc;
    logic        id_use_imm, id_use_pc, id_reg_write;
    logic [3:0]  id_alu_g;
    logic        mem_fwd_en, wb_fwd_en;
    logic [4:0]  mem_fwd_rd, wb_fwd_rd;
    logic [31:0] mem_fwd_data, wb_fwd_data;
    logic        id_ready, ex_valid, ex_reg_write;
    logic [31:0] alu_a, alu_b, ex_store_data;
    logic [3:0]  alu_g;
    logic [4:0]  ex_rd;
`ifdef ALU_OPSTAGE_LOADUSE_EN
    logic        id_mem_read;
    logic        load_use_hazard;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_operand_stage dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
        .id_imm(id_imm), .id_pc(id_pc), .id_use_imm(id_use_imm), .id_use_pc(id_use_pc),
        .id_alu_g(id_alu_g), .id_reg_write(id_reg_write),
`ifdef ALU_OPSTAGE_LOADUSE_EN
        .id_mem_read(id_mem_read), .load_use_hazard(load_use_hazard),
`endif
        .mem_fwd_en(mem_fwd_en), .mem_fwd_rd(mem_fwd_rd), .mem_fwd_data(mem_fwd_data),
        .wb_fwd_en(wb_fwd_en), .wb_fwd_rd(wb_fwd_rd), .wb_fwd_data(wb_fwd_data),
        .id_ready(id_ready), .ex_valid(ex_valid), .alu_a(alu_a), .alu_b(alu_b),
        .alu_g(alu_g), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
        .ex_store_data(ex_store_data)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; flush = 1'b0; id_valid = 1'b1;
        id_rs1 = 5'd1; id_rs2 = 5'd2; id_rd = 5'd6;
        id_rs1_data = 32'h1357; id_rs2_data = 32'h2468; id_imm = 32'h99; id_pc = 32'h400;
        id_use_imm = 1'b1; id_use_pc = 1'b0; id_alu_g = 4'hF; id_reg_write = 1'b1;
        mem_fwd_en = 1'b1; mem_fwd_rd = 5'd1; mem_fwd_data = 32'hCAFE;
        wb_fwd_en = 1'b1; wb_fwd_rd = 5'd2; wb_fwd_data = 32'hBEEF;
`ifdef ALU_OPSTAGE_LOADUSE_EN
        id_mem_read = 1'b1;
`endif
        step(); step();
        chk("rst_valid", {31'd0, ex_valid}, 32'd0);
        chk("rst_a", alu_a, 32'd0);
        chk("rst_b", alu_b, 32'd0);
        chk("rst_g", {28'd0, alu_g}, 32'd0);
        chk("rst_rd", {27'd0, ex_rd}, 32'd0);
        chk("rst_rw", {31'd0, ex_reg_write}, 32'd0);
        chk("rst_sd", ex_store_data, 32'd0);
        chk("rst_ready", {31'd0, id_ready}, 32'd1);

        // plain advance, no forwarding
        rst = 1'b0; mem_fwd_en = 1'b0; wb_fwd_en = 1'b0;
        id_rs1 = 5'd1; id_rs1_data = 32'h5; id_rs2 = 5'd2; id_rs2_data = 32'h77;
        id_imm = 32'h10; id_use_imm = 1'b1; id_use_pc = 1'b0; id_alu_g = 4'b0000;
        id_rd = 5'd3; id_reg_write = 1'b1;
`ifdef ALU_OPSTAGE_LOADUSE_EN
        id_mem_read = 1'b0;
`endif
        step();
        chk("adv_valid", {31'd0, ex_valid}, 32'd1);
        chk("adv_a", alu_a, 32'h5);
        chk("adv_b", alu_b, 32'h10);
        chk("adv_g", {28'd0, alu_g}, 32'd0);
        chk("adv_rd", {27'd0, ex_rd}, 32'd3);
        chk("adv_rw", {31'd0, ex_reg_write}, 32'd1);
        chk("adv_sd", ex_store_data, 32'h77);

        // PC/rs2 operand selection in an invalid slot: write-enable is gated
        id_valid = 1'b0; id_pc = 32'h1000; id_use_pc = 1'b1; id_use_imm = 1'b0;
        id_rs2_data = 32'h22; id_alu_g = 4'b1011; id_rd = 5'd8;
        step();
        chk("pc_a", alu_a, 32'h1000);
        chk("pc_b", alu_b, 32'h22);
        chk("pc_g", {28'd0, alu_g}, 32'hB);
        chk("inv_valid", {31'd0, ex_valid}, 32'd0);
        chk("inv_rw", {31'd0, ex_reg_write}, 32'd0);

        // forwarding priority on rs1=7
        id_valid = 1'b1; id_use_pc = 1'b0; id_rs1 = 5'd7; id_rs1_data = 32'h1111;
        step();
        mem_fwd_en = 1'b1; mem_fwd_rd = 5'd7; mem_fwd_data = 32'hAAAA_0000;
        wb_fwd_en = 1'b1; wb_fwd_rd = 5'd7; wb_fwd_data = 32'h1234;
        #1 chk("fwd_mem", alu_a, 32'hAAAA_0000);
        mem_fwd_en = 1'b0;
        #1 chk("fwd_wb", alu_a, 32'h1234);
        wb_fwd_en = 1'b0;
        #1 chk("fwd_none", alu_a, 32'h1111);
        wb_fwd_en = 1'b1; wb_fwd_rd = 5'd6;
        #1 chk("fwd_miss", alu_a, 32'h1111);

        // index 0 never forwards
        id_rs1 = 5'd0; id_rs1_data = 32'h999;
        mem_fwd_en = 1'b1; mem_fwd_rd = 5'd0; wb_fwd_en = 1'b1; wb_fwd_rd = 5'd0;
        step();
        chk("x0_a", alu_a, 32'd0);
        mem_fwd_en = 1'b0; wb_fwd_en = 1'b0;

        // stall refresh of held rs2
        id_rs2 = 5'd9; id_rs2_data = 32'h5555; id_rd = 5'd11; id_use_imm = 1'b0;
        step();
        chk("st_pre", ex_store_data, 32'h5555);
        stall = 1'b1; wb_fwd_en = 1'b1; wb_fwd_rd = 5'd9; wb_fwd_data = 32'hDEAD_BEEF;
        id_rd = 5'd12; id_rs2 = 5'd10; id_rs2_data = 32'h4242;
        #1 chk("st_ready", {31'd0, id_ready}, 32'd0);
        step();
        wb_fwd_en = 1'b0;
        step();
        chk("st_sd", ex_store_data, 32'hDEAD_BEEF);
        chk("st_b", alu_b, 32'hDEAD_BEEF);
        chk("st_rd_hold", {27'd0, ex_rd}, 32'd11);
        stall = 1'b0;
        step();
        chk("rel_sd", ex_store_data, 32'h4242);
        chk("rel_rd", {27'd0, ex_rd}, 32'd12);

        // flush wins over stall
        stall = 1'b1; flush = 1'b1;
        step();
        chk("fl_valid", {31'd0, ex_valid}, 32'd0);
        chk("fl_rw", {31'd0, ex_reg_write}, 32'd0);
        chk("fl_ready", {31'd0, id_ready}, 32'd0);
        chk("fl_rd", {27'd0, ex_rd}, 32'd0);
        chk("fl_sd", ex_store_data, 32'd0);
        stall = 1'b0; flush = 1'b0;

`ifdef ALU_OPSTAGE_LOADUSE_EN
        id_mem_read = 1'b1; id_rd = 5'd4; id_valid = 1'b1;
        step();
        id_mem_read = 1'b0; id_rs1 = 5'd1; id_rs2 = 5'd4;
        #1 chk("lu_hit", {31'd0, load_use_hazard}, 32'd1);
        id_rs2 = 5'd5;
        #1 chk("lu_miss", {31'd0, load_use_hazard}, 32'd0);
        id_mem_read = 1'b1; id_rd = 5'd0;
        step();
        id_rs1 = 5'd0; id_rs2 = 5'd0;
        #1 chk("lu_x0", {31'd0, load_use_hazard}, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
